// File: rtl/pkt_queue_residue_notifier.sv
// ---------------------------------------------------------------------------
// PktQueueResidueNotifier (module pkt_queue_residue_notifier)
//
// Purpose:
//   Watches software head-pointer writes for the RX packet queues. For each
//   write it reads the queue tail from the shared tail BRAM and compares it
//   with the new head. If the queue still holds data (tail != head), it queues
//   one "extra descriptor request" for that queue toward fpga2cpu. A pending
//   bitmap ensures each queue has at most one outstanding request, so repeated
//   head writes to a busy queue are coalesced instead of queued again.
//
// Ports:
//   clk             single clock
//   rst             asynchronous active-low reset (release synchronised inside)
//   head_upd_valid  software head write, one per cycle, never stalled
//   head_upd_queue  queue of the head write
//   head_upd_ptr    new head value
//   tail_rd_en      tail BRAM read enable (combinational from head_upd_valid)
//   tail_rd_addr    tail BRAM read address
//   tail_rd_data    tail BRAM read data, valid TAIL_RD_LATENCY cycles later
//   tail_wr_en      snooped tail write from the queue manager
//   tail_wr_addr    snooped tail write address
//   tail_wr_data    snooped tail write value
//   dsc_req_valid   extra-descriptor request available
//   dsc_req_queue   queue that needs a descriptor
//   dsc_req_ready   consumer accepts the request
//   req_count       requests enqueued since reset (wraps at 2^32)
//   coalesced_count residue detections dropped because already pending
// ---------------------------------------------------------------------------
module pkt_queue_residue_notifier #(
   parameter int NB_QUEUES       = 16,
   parameter int QUEUE_ID_WIDTH  = $clog2(NB_QUEUES),
   parameter int PTR_WIDTH       = 16,
   parameter int TAIL_RD_LATENCY = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      head_upd_valid,
   input  logic [QUEUE_ID_WIDTH-1:0] head_upd_queue,
   input  logic [PTR_WIDTH-1:0]      head_upd_ptr,
   output logic                      tail_rd_en,
   output logic [QUEUE_ID_WIDTH-1:0] tail_rd_addr,
   input  logic [PTR_WIDTH-1:0]      tail_rd_data,
   input  logic                      tail_wr_en,
   input  logic [QUEUE_ID_WIDTH-1:0] tail_wr_addr,
   input  logic [PTR_WIDTH-1:0]      tail_wr_data,
   output logic                      dsc_req_valid,
   output logic [QUEUE_ID_WIDTH-1:0] dsc_req_queue,
   input  logic                      dsc_req_ready,
   output logic [31:0]               req_count,
   output logic [31:0]               coalesced_count
);

   localparam int QW  = QUEUE_ID_WIDTH;
   localparam int LAT = TAIL_RD_LATENCY;

   // Reset synchroniser: assertion is immediate, release is retimed to clk.
   logic [1:0] rstSync_q;
   logic       rstN;

   // Pipeline stages 1..LAT; stage LAT is the compare stage where the BRAM
   // data arrives. Each stage carries the youngest snooped tail write seen so
   // far for its own queue.
   logic [LAT:1]                stValid_q;
   logic [LAT:1][QW-1:0]        stQueue_q;
   logic [LAT:1][PTR_WIDTH-1:0] stHead_q;
   logic [LAT:1]                stFwdHit_q;
   logic [LAT:1][PTR_WIDTH-1:0] stFwdData_q;

   // Compare stage, pending bitmap and request FIFO state.
   logic [PTR_WIDTH-1:0] effTail;
   logic                 residue;
   logic                 enqFire;
   logic                 coalesceFire;
   logic                 deqFire;
   logic [QW-1:0]        cmpQueue;
   logic [NB_QUEUES-1:0] pendingEff;
   logic [NB_QUEUES-1:0] pending_q;
   logic [NB_QUEUES-1:0] pending_d;

   logic [QW-1:0]        fifoMem_q [NB_QUEUES];
   logic [QW-1:0]        wrPtr_q;
   logic [QW-1:0]        rdPtr_q;
   logic [QW:0]          count_q;
   logic [QW:0]          count_d;
   logic [31:0]          reqCount_q;
   logic [31:0]          coalescedCount_q;

   function automatic logic [NB_QUEUES-1:0] oneHot(input logic [QW-1:0] q);
      logic [NB_QUEUES-1:0] mask;
      mask    = '0;
      mask[q] = 1'b1;
      return mask;
   endfunction

   // Two-flop synchroniser; every other register in the block resets from its
   // output so the whole design leaves reset on the same clock edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rstSync_q <= 2'b00;
      end else begin
         rstSync_q <= {rstSync_q[0], 1'b1};
      end
   end

   assign rstN = rstSync_q[1];

   // The BRAM read is issued in the same cycle as the head write so that its
   // data lines up with the compare stage. Held quiet while in reset.
   assign tail_rd_en   = head_upd_valid & rstN;
   assign tail_rd_addr = rstN ? head_upd_queue : '0;

   // Pipeline registers. A tail write snooped while an update sits in a stage
   // replaces that stage's forwarded value, so the newest write always wins.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         stValid_q   <= '0;
         stQueue_q   <= '0;
         stHead_q    <= '0;
         stFwdHit_q  <= '0;
         stFwdData_q <= '0;
      end else begin
         stValid_q[1] <= head_upd_valid;
         stQueue_q[1] <= head_upd_queue;
         stHead_q[1]  <= head_upd_ptr;
         if (tail_wr_en && (tail_wr_addr == head_upd_queue)) begin
            stFwdHit_q[1]  <= 1'b1;
            stFwdData_q[1] <= tail_wr_data;
         end else begin
            stFwdHit_q[1]  <= 1'b0;
            stFwdData_q[1] <= '0;
         end
         for (int k = 2; k <= LAT; k++) begin
            stValid_q[k] <= stValid_q[k-1];
            stQueue_q[k] <= stQueue_q[k-1];
            stHead_q[k]  <= stHead_q[k-1];
            if (tail_wr_en && (tail_wr_addr == stQueue_q[k-1])) begin
               stFwdHit_q[k]  <= 1'b1;
               stFwdData_q[k] <= tail_wr_data;
            end else begin
               stFwdHit_q[k]  <= stFwdHit_q[k-1];
               stFwdData_q[k] <= stFwdData_q[k-1];
            end
         end
      end
   end

   // Compare stage. A dequeue in this cycle releases its pending bit before
   // the check, so a fresh residue on that queue is requested again and the
   // new set overrides the clear.
   always_comb begin
      cmpQueue = stQueue_q[LAT];
      effTail  = stFwdHit_q[LAT] ? stFwdData_q[LAT] : tail_rd_data;
      if (tail_wr_en && (tail_wr_addr == cmpQueue)) begin
         effTail = tail_wr_data;
      end
      residue    = stValid_q[LAT] && (effTail != stHead_q[LAT]);
      deqFire    = dsc_req_valid && dsc_req_ready;
      pendingEff = pending_q;
      if (deqFire) begin
         pendingEff = pending_q & ~oneHot(dsc_req_queue);
      end
      enqFire      = residue && !pendingEff[cmpQueue];
      coalesceFire = residue && pendingEff[cmpQueue];
      pending_d    = pendingEff;
      if (enqFire) begin
         pending_d = pendingEff | oneHot(cmpQueue);
      end
      count_d = count_q;
      if (enqFire && !deqFire) begin
         count_d = count_q + 1'b1;
      end else if (!enqFire && deqFire) begin
         count_d = count_q - 1'b1;
      end
   end

   // Control state: pending bitmap, FIFO pointers/occupancy and counters. The
   // pending bitmap caps occupancy at NB_QUEUES, so no full check is needed.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         pending_q        <= '0;
         wrPtr_q          <= '0;
         rdPtr_q          <= '0;
         count_q          <= '0;
         reqCount_q       <= '0;
         coalescedCount_q <= '0;
      end else begin
         pending_q <= pending_d;
         count_q   <= count_d;
         if (enqFire) begin
            wrPtr_q    <= wrPtr_q + 1'b1;
            reqCount_q <= reqCount_q + 32'd1;
         end
         if (deqFire) begin
            rdPtr_q <= rdPtr_q + 1'b1;
         end
         if (coalesceFire) begin
            coalescedCount_q <= coalescedCount_q + 32'd1;
         end
      end
   end

   // FIFO storage needs no reset; its contents are only visible while the
   // occupancy count says the slot is live.
   always_ff @(posedge clk) begin
      if (enqFire) begin
         fifoMem_q[wrPtr_q] <= cmpQueue;
      end
   end

   assign dsc_req_valid   = (count_q != '0);
   assign dsc_req_queue   = dsc_req_valid ? fifoMem_q[rdPtr_q] : '0;
   assign req_count       = reqCount_q;
   assign coalesced_count = coalescedCount_q;

endmodule

// File: tb/tb_pkt_queue_residue_notifier.sv
// ---------------------------------------------------------------------------
// Directed testbench for pkt_queue_residue_notifier. Models the tail BRAM
// (two-cycle read latency, written by the snooped tail-write port) and walks
// through residue detection, coalescing, tail forwarding, FIFO ordering and
// asynchronous reset with hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_pkt_queue_residue_notifier;

   localparam int NQ = 16;
   localparam int QW = 4;
   localparam int PW = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          head_upd_valid;
   logic [QW-1:0] head_upd_queue;
   logic [PW-1:0] head_upd_ptr;
   logic          tail_rd_en;
   logic [QW-1:0] tail_rd_addr;
   logic [PW-1:0] tail_rd_data;
   logic          tail_wr_en;
   logic [QW-1:0] tail_wr_addr;
   logic [PW-1:0] tail_wr_data;
   logic          dsc_req_valid;
   logic [QW-1:0] dsc_req_queue;
   logic          dsc_req_ready;
   logic [31:0]   req_count;
   logic [31:0]   coalesced_count;

   logic [PW-1:0] tailMem [NQ];
   logic [PW-1:0] rdPipe;

   int checks   = 0;
   int failures = 0;

   pkt_queue_residue_notifier dut (
      .clk             (clk),
      .rst             (rst),
      .head_upd_valid  (head_upd_valid),
      .head_upd_queue  (head_upd_queue),
      .head_upd_ptr    (head_upd_ptr),
      .tail_rd_en      (tail_rd_en),
      .tail_rd_addr    (tail_rd_addr),
      .tail_rd_data    (tail_rd_data),
      .tail_wr_en      (tail_wr_en),
      .tail_wr_addr    (tail_wr_addr),
      .tail_wr_data    (tail_wr_data),
      .dsc_req_valid   (dsc_req_valid),
      .dsc_req_queue   (dsc_req_queue),
      .dsc_req_ready   (dsc_req_ready),
      .req_count       (req_count),
      .coalesced_count (coalesced_count)
   );

   // Free-running clock, 10 time units per cycle.
   always #5 clk = ~clk;

   // Tail BRAM model: written by the queue manager's tail port, read with a
   // two-cycle latency (address register plus output register).
   always @(posedge clk) begin
      if (tail_wr_en) tailMem[tail_wr_addr] <= tail_wr_data;
      if (tail_rd_en) rdPipe <= tailMem[tail_rd_addr];
      tail_rd_data <= rdPipe;
   end

   // Inputs are driven and outputs sampled 1 unit after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // One-cycle head write; returns one cycle later with the update in S1.
   task automatic applyStimulus(input logic [QW-1:0] q, input logic [PW-1:0] ptr);
      head_upd_valid = 1'b1;
      head_upd_queue = q;
      head_upd_ptr   = ptr;
      step();
      head_upd_valid = 1'b0;
   endtask

   task automatic setTail(input logic [QW-1:0] q, input logic [PW-1:0] v);
      tail_wr_en   = 1'b1;
      tail_wr_addr = q;
      tail_wr_data = v;
      step();
      tail_wr_en   = 1'b0;
   endtask

   task automatic acceptOne();
      dsc_req_ready = 1'b1;
      step();
      dsc_req_ready = 1'b0;
   endtask

   task automatic watchNoRequest(input string tag, input int cycles);
      logic seen;
      seen = 1'b0;
      repeat (cycles) begin
         step();
         if (dsc_req_valid) seen = 1'b1;
      end
      checkOutput(tag, 32'(seen), 32'd0);
   endtask

   initial begin
      rst            = 1'b0;
      head_upd_valid = 1'b1;
      head_upd_queue = 4'd2;
      head_upd_ptr   = '0;
      tail_wr_en     = 1'b0;
      tail_wr_addr   = '0;
      tail_wr_data   = '0;
      dsc_req_ready  = 1'b0;
      step();
      step();
      // Reset state, including a head write held during reset.
      checkOutput("rst_tail_rd_en", 32'(tail_rd_en), 32'd0);
      checkOutput("rst_valid", 32'(dsc_req_valid), 32'd0);
      checkOutput("rst_req_count", req_count, 32'd0);
      checkOutput("rst_coalesced", coalesced_count, 32'd0);
      head_upd_valid = 1'b0;
      rst = 1'b1;
      repeat (4) step();

      // Queue 3 empty (tail == head): no request.
      $display("[TB] empty queue");
      setTail(4'd3, 16'd10);
      head_upd_valid = 1'b1;
      head_upd_queue = 4'd3;
      head_upd_ptr   = 16'd10;
      #1;
      checkOutput("s0_tail_rd_en", 32'(tail_rd_en), 32'd1);
      checkOutput("s0_tail_rd_addr", 32'(tail_rd_addr), 32'd3);
      step();
      head_upd_valid = 1'b0;
      watchNoRequest("empty_no_req", 10);
      checkOutput("empty_req_count", req_count, 32'd0);

      // Queue 3 with residue: request after 3 cycles, accept, re-request.
      $display("[TB] residue and latency");
      setTail(4'd3, 16'd12);
      applyStimulus(4'd3, 16'd10);
      step();
      checkOutput("lat2_valid", 32'(dsc_req_valid), 32'd0);
      step();
      checkOutput("lat3_valid", 32'(dsc_req_valid), 32'd1);
      checkOutput("lat3_queue", 32'(dsc_req_queue), 32'd3);
      checkOutput("lat3_req_count", req_count, 32'd1);
      step();
      checkOutput("hold_valid", 32'(dsc_req_valid), 32'd1);
      checkOutput("hold_queue", 32'(dsc_req_queue), 32'd3);
      acceptOne();
      checkOutput("accept_valid", 32'(dsc_req_valid), 32'd0);
      applyStimulus(4'd3, 16'd10);
      step();
      step();
      checkOutput("rereq_valid", 32'(dsc_req_valid), 32'd1);
      checkOutput("rereq_queue", 32'(dsc_req_queue), 32'd3);
      checkOutput("rereq_req_count", req_count, 32'd2);
      acceptOne();

      // Back-to-back updates to queue 5: one request, one coalesced.
      $display("[TB] coalescing");
      setTail(4'd5, 16'd20);
      applyStimulus(4'd5, 16'd18);
      applyStimulus(4'd5, 16'd19);
      repeat (4) step();
      checkOutput("coal_valid", 32'(dsc_req_valid), 32'd1);
      checkOutput("coal_queue", 32'(dsc_req_queue), 32'd5);
      checkOutput("coal_req_count", req_count, 32'd3);
      checkOutput("coal_coalesced", coalesced_count, 32'd1);
      acceptOne();
      checkOutput("coal_single", 32'(dsc_req_valid), 32'd0);

      // Forwarding: snooped tail write during S1 on the same queue.
      $display("[TB] tail forwarding");
      setTail(4'd7, 16'd4);
      applyStimulus(4'd7, 16'd4);
      tail_wr_en   = 1'b1;
      tail_wr_addr = 4'd7;
      tail_wr_data = 16'd6;
      step();
      tail_wr_en = 1'b0;
      step();
      checkOutput("fwd_valid", 32'(dsc_req_valid), 32'd1);
      checkOutput("fwd_queue", 32'(dsc_req_queue), 32'd7);
      checkOutput("fwd_req_count", req_count, 32'd4);
      acceptOne();

      // Snoop on a different queue must not forward.
      setTail(4'd7, 16'd4);
      setTail(4'd8, 16'd0);
      applyStimulus(4'd7, 16'd4);
      tail_wr_en   = 1'b1;
      tail_wr_addr = 4'd8;
      tail_wr_data = 16'd6;
      step();
      tail_wr_en = 1'b0;
      watchNoRequest("fwd_other_no_req", 6);
      checkOutput("fwd_other_req_count", req_count, 32'd4);

      // Youngest write wins: S1 write makes residue, S2 write removes it.
      setTail(4'd9, 16'd4);
      applyStimulus(4'd9, 16'd4);
      tail_wr_en   = 1'b1;
      tail_wr_addr = 4'd9;
      tail_wr_data = 16'd7;
      step();
      tail_wr_data = 16'd4;
      step();
      tail_wr_en = 1'b0;
      watchNoRequest("fwd_youngest_no_req", 5);
      checkOutput("fwd_youngest_req_count", req_count, 32'd4);

      // All 16 queues with residue, back-to-back, then drain in order.
      $display("[TB] full fifo");
      for (int q = 0; q < NQ; q++) setTail(QW'(q), PW'(q + 100));
      for (int q = 0; q < NQ; q++) begin
         head_upd_valid = 1'b1;
         head_upd_queue = QW'(q);
         head_upd_ptr   = PW'(q);
         step();
      end
      head_upd_valid = 1'b0;
      repeat (3) step();
      checkOutput("full_req_count", req_count, 32'd20);
      dsc_req_ready = 1'b1;
      for (int i = 0; i < NQ; i++) begin
         checkOutput($sformatf("drain_valid_%0d", i), 32'(dsc_req_valid), 32'd1);
         checkOutput($sformatf("drain_queue_%0d", i), 32'(dsc_req_queue), 32'(i));
         step();
      end
      dsc_req_ready = 1'b0;
      checkOutput("drain_empty", 32'(dsc_req_valid), 32'd0);
      checkOutput("drain_coalesced", coalesced_count, 32'd1);

      // Mid-operation reset with 4 queued requests and 2 updates in flight.
      $display("[TB] async reset");
      for (int q = 0; q < 4; q++) applyStimulus(QW'(q), PW'(q));
      repeat (4) step();
      checkOutput("pre_rst_req_count", req_count, 32'd24);
      checkOutput("pre_rst_valid", 32'(dsc_req_valid), 32'd1);
      applyStimulus(4'd10, 16'd10);
      applyStimulus(4'd11, 16'd11);
      #2;
      rst = 1'b0;
      #1;
      checkOutput("async_rst_valid", 32'(dsc_req_valid), 32'd0);
      checkOutput("async_rst_req_count", req_count, 32'd0);
      repeat (3) step();
      rst = 1'b1;
      watchNoRequest("post_rst_no_req", 8);
      checkOutput("post_rst_req_count", req_count, 32'd0);
      checkOutput("post_rst_coalesced", coalesced_count, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pkt_queue_residue_notifier.md
Name: pkt_queue_residue_notifier

Overview:
- Consumes software head-pointer updates for RX packet queues and detects queues that still hold data the host has not been told about (tail != new head).
- For each such queue it emits one "extra descriptor request" toward fpga2cpu, which then sends a descriptor for that queue.
- It is the host-to-FPGA (reader/update) side of the per-queue descriptor-status protocol. It sits beside the packet queue manager and shares its tail table (read port plus tail-write snoop).

Parameters:
- NB_QUEUES, 16, number of packet queues; power of two.
- QUEUE_ID_WIDTH, $clog2(NB_QUEUES), queue index width; derived, not overridden.
- PTR_WIDTH, 16, head/tail pointer width.
- TAIL_RD_LATENCY, 2, tail BRAM read latency in cycles; fixed at 2.

Ports:
- clk  in  1  single clock
- rst  in  1  asynchronous, active-low reset
- head_upd_valid  in  1  software head write for a queue; one per cycle max; cannot be stalled
- head_upd_queue  in  QUEUE_ID_WIDTH  queue of the head write
- head_upd_ptr  in  PTR_WIDTH  new head value
- tail_rd_en  out  1  tail BRAM read enable
- tail_rd_addr  out  QUEUE_ID_WIDTH  tail BRAM read address
- tail_rd_data  in  PTR_WIDTH  tail value, valid 2 cycles after tail_rd_en
- tail_wr_en  in  1  snoop: queue manager writes a tail
- tail_wr_addr  in  QUEUE_ID_WIDTH  snooped tail address
- tail_wr_data  in  PTR_WIDTH  snooped tail value
- dsc_req_valid  out  1  extra-descriptor request available
- dsc_req_queue  out  QUEUE_ID_WIDTH  queue needing a descriptor
- dsc_req_ready  in  1  consumer accepts request
- req_count  out  32  requests enqueued since reset
- coalesced_count  out  32  residue detections dropped because the queue was already pending

Behaviour:
- Reset (rst low, asynchronous):
  - All outputs 0; pipeline valids 0; request FIFO empty.
  - Pending bitmap all 0; counters 0.
  - Deassertion is synchronised internally. The first update is accepted in the first cycle after release.
- Pipeline is fully pipelined, one update per cycle, 3 stages:
  - S0: on head_upd_valid, drive tail_rd_en=1 and tail_rd_addr=queue in the same cycle (combinational from input). Register queue, head and valid into S1.
  - S1: hold.
  - S2: tail_rd_data valid; compare.
- Tail forwarding:
  - Track snooped tail writes that coincide with S0, S1 or S2 and target the S2 queue.
  - The effective tail is the youngest matching snooped write. If there is none, use tail_rd_data.
  - A write in the same cycle as S2 takes priority over older ones.
- Compare in S2:
  - residue = (effective_tail != head). Equality means empty; no wrap arithmetic is needed.
  - If residue and the queue is not pending: enqueue the queue id, set pending[q], and increment req_count.
  - If residue and the queue is pending: drop and increment coalesced_count.
  - No residue: nothing happens.
- Pending visibility:
  - Pending includes a bypass from the previous-cycle S2 enqueue, so back-to-back updates to the same queue yield one request.
  - A dequeue of q in the same cycle clears pending before the S2 check. The new request is then enqueued and pending re-set; the set wins.
- Request FIFO:
  - Depth NB_QUEUES. The pending bitmap bounds occupancy, so the FIFO never overflows and never backpressures the pipeline.
  - Output is valid/ready, FIFO-ordered. A request is transferred when dsc_req_valid && dsc_req_ready.
  - On transfer, pending[dsc_req_queue] clears. dsc_req_valid/dsc_req_queue are stable while not accepted.
- Counters are 32-bit and wrap at 2^32.
- Latency: head update to dsc_req_valid is 3 cycles when the FIFO is empty (S0 -> S2 compare -> FIFO output registered).
- Mid-operation reset: in-flight updates and queued requests are discarded. Software must re-issue a head write to obtain notification.

Test Plan:
- Queue 3, tail=10 in BRAM, head write 10 -> no dsc_req_valid within 10 cycles; req_count=0.
- Queue 3, tail=12, head write 10 -> dsc_req_valid at cycle 3 with queue=3; req_count=1. Accept with ready=1 -> pending[3] clears. A repeat head write 10 yields another request.
- Queue 5, tail=20, head writes 18 then 19 on consecutive cycles, ready=0 -> exactly one request (queue 5); coalesced_count=1.
- Queue 7, BRAM tail=4, head write 4; snooped tail write to queue 7 value 6 one cycle later (during S1) -> request for queue 7 issued (forwarding). Repeat with the snoop on queue 8 -> no request.
- All 16 queues with residue, head writes on 16 consecutive cycles, ready=0 -> 16 requests queued in order 0..15, no loss. Then ready=1 drains 0..15 in 16 cycles.
- Assert rst with 4 requests queued and 2 updates in flight -> dsc_req_valid=0 immediately (asynchronous); after release, counters are 0 and no request appears.
